// File: rtl/dvsd_seqmul.sv
// Sequential radix-2 shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, unsigned or
// two's-complement per operation, with a START/BUSY/DONE handshake.
module dvsd_seqmul #(
  parameter int WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic                 SIGNED,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [2*WIDTH-1:0]   M
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t                state;
  logic [WIDTH-1:0]      mcand;
  logic [WIDTH-1:0]      mplier;
  logic [2*WIDTH-1:0]    acc;
  logic                  neg;
  logic [CNT_W-1:0]      cnt;
  logic [WIDTH:0]        sum;
  logic [WIDTH-1:0]      a_mag;
  logic [WIDTH-1:0]      b_mag;
  logic                  op_neg;

  // Magnitude of a possibly-signed operand; the most negative value maps to
  // 2^(WIDTH-1), which still fits as an unsigned WIDTH-bit number.
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] x,
                                                 input logic                    sgn);
    logic signed [WIDTH-1:0] nx;
    nx = -x;
    return (sgn && x[WIDTH-1]) ? $unsigned(nx) : $unsigned(x);
  endfunction

  function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] p,
                                                    input logic               n);
    return n ? -p : p;
  endfunction

  always_comb begin
    a_mag  = magnitude(A, SIGNED);
    b_mag  = magnitude(B, SIGNED);
    op_neg = SIGNED & (A[WIDTH-1] ^ B[WIDTH-1]);
  end

  // Upper half plus conditional multiplicand; bit WIDTH is the carry that is
  // shifted back into the accumulator.
  assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      M      <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      neg    <= 1'b0;
      cnt    <= '0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            mcand  <= a_mag;
            mplier <= b_mag;
            neg    <= op_neg;
            acc    <= '0;
            cnt    <= CNT_W'(WIDTH);
            BUSY   <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          acc    <= {sum, acc[WIDTH-1:1]};
          mplier <= mplier >> 1;
          cnt    <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            BUSY  <= 1'b0;
            state <= FIN;
          end
        end
        FIN: begin
          M    <= apply_sign(acc, neg);
          DONE <= 1'b1;
          // A request here is accepted immediately for back-to-back throughput.
          if (START) begin
            mcand  <= a_mag;
            mplier <= b_mag;
            neg    <= op_neg;
            acc    <= '0;
            cnt    <= CNT_W'(WIDTH);
            BUSY   <= 1'b1;
            state  <= CALC;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          BUSY  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dvsd_seqmul.sv
// Testbench for dvsd_seqmul: directed vector table, handshake corner sequences,
// a WIDTH=4 instance and randomized operations against an arithmetic model.
module tb_dvsd_seqmul;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, sgn;
  logic [7:0]  a, b;
  logic        busy, done;
  logic [15:0] m;

  logic        start4, sgn4;
  logic [3:0]  a4, b4;
  logic        busy4, done4;
  logic [7:0]  m4;

  int n_tests = 0;
  int n_fail  = 0;

  dvsd_seqmul #(.WIDTH(8)) u_dut8 (
    .CLK(clk), .RST(rst), .START(start), .SIGNED(sgn),
    .A(a), .B(b), .BUSY(busy), .DONE(done), .M(m)
  );

  dvsd_seqmul #(.WIDTH(4)) u_dut4 (
    .CLK(clk), .RST(rst), .START(start4), .SIGNED(sgn4),
    .A(a4), .B(b4), .BUSY(busy4), .DONE(done4), .M(m4)
  );

  typedef struct {
    logic        sg;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] m;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Exact product from plain integer arithmetic, truncated to 2*w bits.
  function automatic int ref_mul(input logic sg, input int x, input int y, input int w);
    int px, py;
    px = x;
    py = y;
    if (sg && px >= (1 << (w - 1))) px -= (1 << w);
    if (sg && py >= (1 << (w - 1))) py -= (1 << w);
    return (px * py) & ((1 << (2 * w)) - 1);
  endfunction

  task automatic run_op8(input logic sg, input logic [7:0] x, input logic [7:0] y,
                         output logic [15:0] res, output int lat, output int busy_cnt);
    @(negedge clk);
    start = 1'b1; sgn = sg; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    busy_cnt = 0;
    while (done !== 1'b1 && lat < 50) begin
      if (busy === 1'b1) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
    res = m;
  endtask

  task automatic run_op4(input logic sg, input logic [3:0] x, input logic [3:0] y,
                         output logic [7:0] res, output int lat);
    @(negedge clk);
    start4 = 1'b1; sgn4 = sg; a4 = x; b4 = y;
    @(posedge clk); #1;
    start4 = 1'b0;
    lat = 0;
    while (done4 !== 1'b1 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    res = m4;
  endtask

  initial begin
    logic [15:0] r;
    logic [7:0]  r4;
    int          lat, bcnt, ndone, dlat, bad;
    logic [15:0] mres;

    vecs[0] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
    vecs[1] = '{1'b1, 8'hFF, 8'hFF, 16'h0001};
    vecs[2] = '{1'b1, 8'h80, 8'h7F, 16'hC080};
    vecs[3] = '{1'b1, 8'h80, 8'h80, 16'h4000};
    vecs[4] = '{1'b1, 8'h00, 8'h85, 16'h0000};
    vecs[5] = '{1'b0, 8'h0C, 8'h0A, 16'h0078};

    rst = 1'b1; start = 1'b0; sgn = 1'b0; a = '0; b = '0;
    start4 = 1'b0; sgn4 = 1'b0; a4 = '0; b4 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy8", 32'(busy), 32'd0);
    check("reset_done8", 32'(done), 32'd0);
    check("reset_m8",    32'(m),    32'd0);
    check("reset_busy4", 32'(busy4), 32'd0);
    check("reset_done4", 32'(done4), 32'd0);
    check("reset_m4",    32'(m4),    32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_op8(vecs[i].sg, vecs[i].a, vecs[i].b, r, lat, bcnt);
      check($sformatf("vec%0d_m", i),    32'(r),  32'(vecs[i].m));
      check($sformatf("vec%0d_lat", i),  lat,     32'd9);
      check($sformatf("vec%0d_busy", i), bcnt,    32'd8);
      check($sformatf("vec%0d_model", i), 32'(vecs[i].m),
            ref_mul(vecs[i].sg, int'(vecs[i].a), int'(vecs[i].b), 8));
    end

    // Back-to-back: START held, new operands presented in the FIN cycle.
    @(negedge clk);
    sgn = 1'b0; a = 8'h0C; b = 8'h0A; start = 1'b1;
    @(posedge clk); #1;
    bad = 0;
    for (int i = 1; i <= 18; i++) begin
      @(posedge clk); #1;
      if (i == 8) begin
        a = 8'h03; b = 8'h05;
      end
      if (i == 9) begin
        check("b2b_done1", 32'(done), 32'd1);
        check("b2b_m1",    32'(m),    32'h0078);
        check("b2b_busy_after_fin", 32'(busy), 32'd1);
        start = 1'b0;
      end else if (i == 18) begin
        check("b2b_done2", 32'(done), 32'd1);
        check("b2b_m2",    32'(m),    32'h000F);
      end else if (i > 9) begin
        if (done !== 1'b0 || m !== 16'h0078) bad++;
      end else begin
        if (done !== 1'b0) bad++;
      end
    end
    check("b2b_hold", bad, 32'd0);

    // START pulsed while busy must be ignored.
    @(negedge clk);
    sgn = 1'b0; a = 8'h10; b = 8'h10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0; dlat = 0; mres = '0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (i == 3) begin
        start = 1'b1; a = 8'hFF; b = 8'hFF;
      end
      if (i == 4) start = 1'b0;
      if (done === 1'b1) begin
        ndone++; mres = m; dlat = i;
      end
    end
    check("busy_ignore_ndone", ndone, 32'd1);
    check("busy_ignore_m",     32'(mres), 32'h0100);
    check("busy_ignore_lat",   dlat, 32'd9);
    check("busy_ignore_idle",  32'(busy), 32'd0);

    // Reset in the middle of an operation.
    @(negedge clk);
    sgn = 1'b0; a = 8'hFF; b = 8'h02; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (i == 3) rst = 1'b1;
      if (i == 4) begin
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_m",    32'(m),    32'd0);
        rst = 1'b0;
      end
      if (i > 4 && done === 1'b1) ndone++;
    end
    check("midrst_no_done", ndone, 32'd0);
    run_op8(1'b0, 8'h02, 8'h03, r, lat, bcnt);
    check("after_rst_m",   32'(r), 32'h0006);
    check("after_rst_lat", lat,    32'd9);

    // WIDTH=4 instance.
    run_op4(1'b0, 4'hF, 4'hF, r4, lat);
    check("w4_unsigned_m",   32'(r4), 32'h00E1);
    check("w4_unsigned_lat", lat,     32'd5);
    run_op4(1'b1, 4'h8, 4'h7, r4, lat);
    check("w4_signed_m",   32'(r4), 32'h00C8);
    check("w4_signed_lat", lat,     32'd5);
    for (int i = 0; i < 10; i++) begin
      logic       sg;
      logic [3:0] x, y;
      sg = 1'($urandom_range(0, 1));
      x  = 4'($urandom);
      y  = 4'($urandom);
      run_op4(sg, x, y, r4, lat);
      check($sformatf("w4_rand%0d_s%0d_%0h_%0h", i, sg, x, y), 32'(r4),
            ref_mul(sg, int'(x), int'(y), 4));
    end

    // Randomized WIDTH=8 operations against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      logic       sg;
      logic [7:0] x, y;
      sg = 1'($urandom_range(0, 1));
      x  = 8'($urandom);
      y  = 8'($urandom);
      run_op8(sg, x, y, r, lat, bcnt);
      check($sformatf("rand%0d_s%0d_%0h_%0h", i, sg, x, y), 32'(r),
            ref_mul(sg, int'(x), int'(y), 8));
      check($sformatf("rand%0d_lat", i), lat, 32'd9);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dvsd_seqmul.md
Name: dvsd_seqmul

Overview:
- Parametrised, sequential successor to the dvsd 8x8 combinational multiplier.
- Computes the 2*WIDTH-bit product of two WIDTH-bit operands with a radix-2 shift-add datapath, one multiplier bit per cycle.
- Supports unsigned and signed (two's complement) modes, selected per operation.
- Trades area for latency; a START/BUSY/DONE handshake lets it sit behind a simple controller or bus register block.

Parameters:
WIDTH, 8, operand width in bits (>= 2); product width is 2*WIDTH.

Ports:
CLK  in  1  rising-edge clock.
RST  in  1  synchronous reset, active-high.
START  in  1  request; sampled only when BUSY=0.
SIGNED  in  1  1 = two's-complement operands/product; 0 = unsigned; sampled with START.
A  in  WIDTH  multiplicand; sampled with START.
B  in  WIDTH  multiplier; sampled with START.
BUSY  out  1  high while an operation is in progress.
DONE  out  1  one-cycle pulse; M valid and updated in this cycle.
M  out  2*WIDTH  product; holds last result until the next DONE.

Behaviour:
- Reset: RST high at a CLK edge forces state IDLE and BUSY=0, DONE=0, M=0. Internal accumulator, operand registers, sign flag and counter are cleared.
- Reset mid-operation abandons the operation: no DONE, M=0.
- States: IDLE, CALC, FIN.
- IDLE:
  - START=1 at an edge captures the operands. SIGNED=1 loads |A| and |B| into WIDTH-bit magnitude registers and stores neg = A[MSB]^B[MSB]. SIGNED=0 loads A and B as-is with neg=0.
  - The same edge clears the accumulator, sets counter=WIDTH and moves to CALC.
  - |-2^(WIDTH-1)| = 2^(WIDTH-1) fits unsigned in WIDTH bits; no overflow.
- CALC, one step per cycle:
  - If the multiplier LSB = 1, add the multiplicand to the upper half of the accumulator, with carry kept.
  - Shift {carry, accumulator} right by 1 and shift the multiplier right by 1; decrement the counter.
  - After WIDTH steps, go to FIN.
- FIN:
  - M <= neg ? (~acc + 1) : acc; DONE=1; BUSY=0.
  - Next state is IDLE, or CALC if START=1 in FIN. This gives back-to-back acceptance with the new operands captured in the FIN cycle.
- BUSY=1 in CALC only; BUSY=0 in IDLE and FIN.
- Latency: START sampled at edge k → BUSY high after k → DONE high for exactly one cycle after edge k+WIDTH+1. WIDTH=8 gives 9 cycles from accept to DONE.
- Throughput: one result per WIDTH+1 cycles.
- START while BUSY=1 is ignored; it is not queued. A, B and SIGNED may change freely while BUSY=1.
- Results are exact in both modes; no truncation or saturation.
  - Signed range: -2^(WIDTH-1)*(2^(WIDTH-1)-1) … 2^(2*WIDTH-2).
  - Zero with neg=1 yields 0; the negate of 0 is 0.
- M changes only at the DONE edge or on reset.

Test Plan:
1. WIDTH=8, SIGNED=0, A=0xFF, B=0xFF, START 1 cycle → DONE pulse exactly 9 cycles after accept, M=0xFE01, BUSY high for the 8 intervening cycles.
2. WIDTH=8, SIGNED=1: A=0xFF, B=0xFF → M=0x0001. A=0x80, B=0x7F → M=0xC080. A=0x80, B=0x80 → M=0x4000. A=0x00, B=0x85 → M=0x0000.
3. Back-to-back: hold START=1 with SIGNED=0, A=0x0C, B=0x0A, then change to A=0x03, B=0x05 in the FIN cycle → DONE pulses 9 cycles apart with M=0x0078 then M=0x000F; M holds 0x0078 between the pulses.
4. Ignore while busy: start A=0x10, B=0x10; 3 cycles later pulse START with A=0xFF, B=0xFF → a single DONE with M=0x0100, and no second operation.
5. Reset mid-op: start A=0xFF, B=0x02; assert RST at step 4 → next cycle BUSY=0, DONE=0, M=0 and no DONE follows. A new op A=0x02, B=0x03 then gives M=0x0006.
6. WIDTH=4 instance: SIGNED=0, A=0xF, B=0xF → M=0xE1 after 5 cycles. SIGNED=1, A=0x8, B=0x7 → M=0xC8.
